// File: rtl/ascii_num_fmt_pkg.sv
// Shared character-type definitions for the ASCII number formatter:
// ASCII constants, the formatter FSM state enum and the digit-to-character mapping.
package ascii_num_fmt_pkg;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_a  = 8'h61;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {IDLE, CONV, SIZE, PAD, DIG} fmt_state_e;

  // Digits 10..15 become letters; the case comes from the request's upper flag
  function automatic logic [7:0] digit_char(input logic [3:0] d, input logic upper);
    if (d < 4'd10) return CH_0 + {4'd0, d};
    return (upper ? CH_A : CH_a) + {4'd0, d} - 8'd10;
  endfunction

endpackage

// File: rtl/ascii_num_fmt_if.sv
// Request and character-stream handshake bundle of the ASCII number formatter.
interface ascii_num_fmt_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             in_hex;
  logic             in_upper;
  logic             in_zpad;
  logic [4:0]       in_fwidth;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_last;

  modport master (
    output in_valid, in_value, in_hex, in_upper, in_zpad, in_fwidth, out_ready,
    input  in_ready, out_valid, out_char, out_last
  );

  modport slave (
    input  in_valid, in_value, in_hex, in_upper, in_zpad, in_fwidth, out_ready,
    output in_ready, out_valid, out_char, out_last
  );

endinterface

// File: rtl/ascii_num_fmt_bin2bcd.sv
// Iterative double-dabble converter: one input bit per cycle, WIDTH cycles per value.
module bin2bcd_seq #(
  parameter int WIDTH = 32,
  parameter int NDEC  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*NDEC-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 4 * NDEC;

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDEC; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // High during the cycle whose closing edge performs the final shift
  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
      bcd   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(WIDTH);
      shreg <= bin;
      bcd   <= '0;
    end else if (busy) begin
      bcd   <= (adj << 1) | DW'(shreg[WIDTH-1]);
      shreg <= shreg << 1;
      cnt   <= cnt - CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ascii_num_fmt.sv
// Streaming unsigned-to-ASCII formatter: right-justified decimal or hex text,
// padded to a minimum field width, one character per valid/ready beat.
module ascii_num_fmt
  import ascii_num_fmt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NDEC  = 10
) (
  input logic            clk,
  input logic            rst,
  ascii_num_fmt_if.slave bus
);

  localparam int DW = 4 * NDEC;

  fmt_state_e       state;
  logic [WIDTH-1:0] val_q;
  logic             hex_q, upper_q, zpad_q;
  logic [4:0]       fwidth_q;
  logic [DW-1:0]    digs_q;
  logic [6:0]       pad_cnt, dig_idx;

  logic             conv_start, conv_busy, conv_done;
  logic [DW-1:0]    bcd;
  logic [DW-1:0]    size_digs;
  logic [6:0]       n_sig, pad_len;
  logic [7:0]       pad_ch;

  assign conv_start = bus.in_valid && bus.in_ready && !bus.in_hex;
  assign pad_ch     = zpad_q ? CH_0 : CH_SP;

  bin2bcd_seq #(.WIDTH(WIDTH), .NDEC(NDEC)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (bus.in_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Hex nibbles are already digits, so only decimal needs the BCD result
  always_comb begin
    size_digs = hex_q ? DW'(val_q) : bcd;
    n_sig = 7'd1;
    for (int i = 1; i < NDEC; i++) begin
      if (size_digs[4*i +: 4] != 4'd0) n_sig = 7'(i + 1);
    end
    pad_len = ({2'b00, fwidth_q} > n_sig) ? ({2'b00, fwidth_q} - n_sig) : 7'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_char  <= 8'h00;
      bus.out_last  <= 1'b0;
      val_q         <= '0;
      hex_q         <= 1'b0;
      upper_q       <= 1'b0;
      zpad_q        <= 1'b0;
      fwidth_q      <= '0;
      digs_q        <= '0;
      pad_cnt       <= '0;
      dig_idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            val_q        <= bus.in_value;
            hex_q        <= bus.in_hex;
            upper_q      <= bus.in_upper;
            zpad_q       <= bus.in_zpad;
            fwidth_q     <= bus.in_fwidth;
            bus.in_ready <= 1'b0;
            state        <= CONV;
          end
        end
        CONV: begin
          if (hex_q || (conv_busy && conv_done)) state <= SIZE;
        end
        SIZE: begin
          digs_q  <= size_digs;
          dig_idx <= n_sig - 7'd1;
          pad_cnt <= pad_len;
          state   <= (pad_len != 7'd0) ? PAD : DIG;
        end
        // The last pad char is still in the output register when DIG is entered
        PAD: begin
          if (!bus.out_valid || bus.out_ready) begin
            bus.out_char  <= pad_ch;
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b0;
            pad_cnt       <= pad_cnt - 7'd1;
            if (pad_cnt == 7'd1) state <= DIG;
          end
        end
        DIG: begin
          if (bus.out_valid && bus.out_ready && bus.out_last) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end else if (!bus.out_valid || bus.out_ready) begin
            bus.out_char  <= digit_char(digs_q[4*dig_idx +: 4], upper_q);
            bus.out_valid <= 1'b1;
            bus.out_last  <= (dig_idx == 7'd0);
            dig_idx       <= dig_idx - 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
